// File: rtl/store_buffer.sv
// Store buffer: in-order FIFO of pending stores that drains to the data-memory
// port whenever loads leave it free. Load forwarding is enabled by STORE_BUFFER_FWD_EN.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        st_err,
    input  logic        ld_valid,
    input  logic [1:0]  ld_op,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    output logic        ld_fwd,
    output logic [31:0] ld_fwd_data,
    input  logic        dm_busy,
    output logic        DM_write,
    output logic [1:0]  DMop,
    output logic [31:0] DM_addr,
    output logic [31:0] DM_WD,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [1:0]  op_mem   [DEPTH];
    logic [31:0] addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [PTR_W:0]   count_reg, count_next;
    logic             err_reg, err_next;

    logic             legal;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] match;
    logic             any_match;
    logic             ld_addr_unused;

    assign ld_addr_unused = ^ld_addr[1:0];

    always_comb begin
        case (st_op)
            2'd0:    legal = (st_addr[1:0] == 2'b00);
            2'd1:    legal = ~st_addr[0];
            2'd2:    legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign st_ready = (count_reg != FULL_CNT);
    assign empty    = (count_reg == '0);
    assign st_err   = err_reg;
    assign push     = st_valid & st_ready & legal;
    assign pop      = ~empty & ~dm_busy;
    assign err_next = st_valid & st_ready & ~legal;

    assign DM_write = pop;
    assign DMop     = pop ? op_mem[head_reg]   : 2'd0;
    assign DM_addr  = pop ? addr_mem[head_reg] : 32'd0;
    assign DM_WD    = pop ? data_mem[head_reg] : 32'd0;

    // An entry is live when its distance from head is below count; the store
    // being accepted this cycle is not yet in the array, so it never matches.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [PTR_W-1:0] age;
            assign age       = PTR_W'(gi) - head_reg;
            assign match[gi] = ({1'b0, age} < count_reg) &&
                               (addr_mem[gi][31:2] == ld_addr[31:2]);
        end
    endgenerate

    assign any_match = |match;

`ifdef STORE_BUFFER_FWD_EN
    logic [PTR_W-1:0] young_idx;
    logic [PTR_W-1:0] scan_idx;
    logic             can_fwd;

    // Walk from oldest to youngest so the last hit is the youngest match.
    always_comb begin
        young_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_reg + PTR_W'(k);
            if (match[scan_idx])
                young_idx = scan_idx;
        end
    end

    assign can_fwd     = (op_mem[young_idx] == 2'd0) && (ld_op == 2'd0);
    assign ld_fwd      = ld_valid & any_match & can_fwd;
    assign ld_stall    = ld_valid & any_match & ~can_fwd;
    assign ld_fwd_data = ld_fwd ? data_mem[young_idx] : 32'd0;
`else
    logic ld_op_unused;

    assign ld_op_unused = ^ld_op;
    assign ld_fwd       = 1'b0;
    assign ld_fwd_data  = 32'd0;
    assign ld_stall     = ld_valid & any_match;
`endif

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (pop)
            head_next = head_reg + 1'b1;
        if (push)
            tail_next = tail_reg + 1'b1;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    // Entry payload needs no reset: liveness comes from head/count only.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[tail_reg]   <= st_op;
            addr_mem[tail_reg] <= st_addr;
            data_mem[tail_reg] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// compared against a queue-based model of the pending stores.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        st_err;
    logic        ld_valid;
    logic [1:0]  ld_op;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        ld_fwd;
    logic [31:0] ld_fwd_data;
    logic        dm_busy;
    logic        DM_write;
    logic [1:0]  DMop;
    logic [31:0] DM_addr;
    logic [31:0] DM_WD;
    logic        empty;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready), .st_err(st_err),
        .ld_valid(ld_valid), .ld_op(ld_op), .ld_addr(ld_addr),
        .ld_stall(ld_stall), .ld_fwd(ld_fwd), .ld_fwd_data(ld_fwd_data),
        .dm_busy(dm_busy),
        .DM_write(DM_write), .DMop(DMop), .DM_addr(DM_addr), .DM_WD(DM_WD),
        .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    bit   err_m;
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic bit is_legal(input logic [1:0] op, input logic [31:0] a);
        case (op)
            2'd0:    return a[1:0] == 2'b00;
            2'd1:    return a[0] == 1'b0;
            2'd2:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic rst, input logic sv, input logic [1:0] sop,
                         input logic [31:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [1:0] lop, input logic [31:0] la,
                         input logic busy);
        @(negedge clk);
        reset = rst; st_valid = sv; st_op = sop; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_op = lop; ld_addr = la; dm_busy = busy;
        #1;
    endtask

    // Expected outputs derived from the model queue and current inputs.
    task automatic check_all();
        bit          drain;
        bit          found;
        bit          fwd_ok;
        logic [31:0] fdata;
        drain  = (q.size() > 0) && !dm_busy;
        found  = 1'b0;
        fwd_ok = 1'b0;
        fdata  = 32'd0;
        if (ld_valid) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].addr[31:2] == ld_addr[31:2]) begin
                    found = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                    fwd_ok = (q[i].op == 2'd0) && (ld_op == 2'd0);
                    fdata  = q[i].data;
`endif
                    break;
                end
            end
        end
        chk("st_ready", 32'(st_ready), 32'(q.size() != DEPTH));
        chk("empty",    32'(empty),    32'(q.size() == 0));
        chk("st_err",   32'(st_err),   32'(err_m));
        chk("DM_write", 32'(DM_write), 32'(drain));
        chk("DMop",     32'(DMop),     drain ? 32'(q[0].op) : 32'd0);
        chk("DM_addr",  DM_addr,       drain ? q[0].addr : 32'd0);
        chk("DM_WD",    DM_WD,         drain ? q[0].data : 32'd0);
        chk("ld_stall", 32'(ld_stall), 32'(found && !fwd_ok));
        chk("ld_fwd",   32'(ld_fwd),   32'(found && fwd_ok));
        chk("ld_fwd_data", ld_fwd_data, (found && fwd_ok) ? fdata : 32'd0);
    endtask

    task automatic tick();
        bit   full, acc, pop, err_n;
        ent_t e;
        full  = (q.size() == DEPTH);
        acc   = st_valid && !full && is_legal(st_op, st_addr);
        err_n = st_valid && !full && !is_legal(st_op, st_addr);
        pop   = (q.size() > 0) && !dm_busy;
        e.op = st_op; e.addr = st_addr; e.data = st_data;
        @(posedge clk);
        if (reset) begin
            q.delete();
            err_m = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
            err_m = err_n;
        end
    endtask

    task automatic step(input logic rst, input logic sv, input logic [1:0] sop,
                        input logic [31:0] sa, input logic [31:0] sd,
                        input logic lv, input logic [1:0] lop, input logic [31:0] la,
                        input logic busy);
        drive(rst, sv, sop, sa, sd, lv, lop, la, busy);
        check_all();
        tick();
    endtask

    initial begin
        err_m = 1'b0;
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_all();
        tick();

        // Single word store drains next cycle.
        step(0, 1, 2'd0, 32'h0, 32'habcd5555, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_all();
        chk("req022_write", 32'(DM_write), 32'd1);
        chk("req022_wd",    DM_WD, 32'habcd5555);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("req022_empty", 32'(empty), 32'd1);
        check_all();
        tick();

        // Fill while busy, overflow ignored, then in-order back-to-back drain.
        for (int i = 0; i < 4; i++)
            step(0, 1, 2'd0, 32'h100 + 32'(4 * i), 32'h500 + 32'(i), 0, 0, 0, 1);
        drive(0, 1, 2'd0, 32'h200, 32'h999, 0, 0, 0, 1);
        chk("req023_full", 32'(st_ready), 32'd0);
        check_all();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("req023_no_err", 32'(st_err), 32'd0);
        check_all();
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("req023_order", DM_addr, 32'h100 + 32'(4 * i));
            check_all();
            tick();
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Misaligned word rejected; misaligned byte accepted.
        step(0, 1, 2'd0, 32'h2, 32'h77, 0, 0, 0, 0);
        drive(0, 1, 2'd2, 32'h3, 32'hfe, 0, 0, 0, 0);
        chk("req024_err", 32'(st_err), 32'd1);
        chk("req024_empty", 32'(empty), 32'd1);
        check_all();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("req024_err_clr", 32'(st_err), 32'd0);
        chk("req024_wd", DM_WD, 32'hfe);
        check_all();
        tick();

        // Forwarding from youngest matching word.
        step(0, 1, 2'd0, 32'h4, 32'h11, 0, 0, 0, 1);
        step(0, 1, 2'd0, 32'h4, 32'h22, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 2'd0, 32'h4, 1);
`ifdef STORE_BUFFER_FWD_EN
        chk("req025_fwd", 32'(ld_fwd), 32'd1);
        chk("req025_data", ld_fwd_data, 32'h22);
`else
        chk("req025_stall_w", 32'(ld_stall), 32'd1);
`endif
        check_all();
        tick();
        drive(0, 0, 0, 0, 0, 1, 2'd2, 32'h5, 1);
        chk("req025_stall_b", 32'(ld_stall), 32'd1);
        check_all();
        tick();

        // Reset discards pending entries.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("req026_empty", 32'(empty), 32'd1);
        chk("req026_write", 32'(DM_write), 32'd0);
        chk("req026_ready", 32'(st_ready), 32'd1);
        check_all();
        tick();

        // Random traffic over a small address window to provoke matches.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 59) == 0),
                 $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                 32'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                 32'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have exactly these parameters: DEPTH, default 4, number of store entries (power of two, 2..8).
REQ-002 The port list SHALL be, in order:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- st_valid  in  1  pipeline presents a store this cycle
- st_op  in  2  store width: 0=word, 1=half, 2=byte, 3=illegal
- st_addr  in  32  store byte address
- st_data  in  32  store data, right-aligned
- st_ready  out  1  buffer can accept a store this cycle
- st_err  out  1  one-cycle pulse for a rejected store
- ld_valid  in  1  pipeline is issuing a load this cycle
- ld_op  in  2  load width, same encoding as st_op
- ld_addr  in  32  load byte address
- ld_stall  out  1  load must be held; buffer conflict
- ld_fwd  out  1  load satisfied from buffer
- ld_fwd_data  out  32  forwarded word
- dm_busy  in  1  DM port taken by a load this cycle
- DM_write  out  1  DM write enable
- DMop  out  2  DM access width, same encoding
- DM_addr  out  32  DM byte address
- DM_WD  out  32  DM write data
- empty  out  1  no pending stores

Function
REQ-003 Storage SHALL be a circular FIFO of DEPTH entries {op, addr, data}, head/tail pointers wrapping modulo DEPTH, count 0..DEPTH.
REQ-004 st_ready SHALL equal (count != DEPTH); no credit for a same-cycle pop.
REQ-005 Accept: st_valid & st_ready & legal -> entry written at tail at the edge; count+1 unless a pop occurs same edge (then unchanged).
REQ-006 Legal store: op 0 with addr[1:0]=0; op 1 with addr[0]=0; op 2 any addr; op 3 never legal.
REQ-007 Illegal store with st_valid & st_ready SHALL not be enqueued and SHALL set st_err high for exactly the next cycle.
REQ-008 st_valid while full SHALL be ignored (no enqueue, no st_err); pipeline holds it.
REQ-009 Drain: when count>0 and dm_busy=0, DM_write=1 and DMop/DM_addr/DM_WD = head entry, combinationally in that cycle; head pops at that edge.
REQ-010 When count=0 or dm_busy=1, DM_write SHALL be 0 and DMop/DM_addr/DM_WD SHALL be 0.
REQ-011 Minimum latency: store accepted at edge N appears on the DM port in cycle N+1 earliest; one drain per cycle max.
REQ-012 Stores drain strictly in acceptance order.
REQ-013 Load match: valid entry with addr[31:2] == ld_addr[31:2]; entry being accepted this cycle excluded; entry popping this cycle included.
REQ-014 ld_stall, ld_fwd asserted only while ld_valid=1; never both; ld_fwd_data=0 when ld_fwd=0.
REQ-015 No matching entry: ld_stall=0, ld_fwd=0.
REQ-016 empty SHALL equal (count == 0).

Reset
REQ-017 On reset at an edge: count=0, head=tail=0, st_err=0; pending stores discarded, including mid-drain; no DM write the following cycle.
REQ-018 Outputs after reset: st_ready=1, empty=1, DM_write=0, DM port=0, ld_stall=0, ld_fwd=0, ld_fwd_data=0.

Configuration
REQ-019 Macro STORE_BUFFER_FWD_EN SHALL gate forwarding.
REQ-020 Defined: youngest matching entry op=0 and ld_op=0 -> ld_fwd=1, ld_fwd_data=its data, ld_stall=0; any other match -> ld_stall=1.
REQ-021 Undefined: ld_fwd and ld_fwd_data tied 0; any match -> ld_stall=1.

Verification
REQ-022 Reset, push word 0xabcd5555 @0x0, dm_busy=0 -> next cycle DM_write=1, DMop=0, DM_addr=0, DM_WD=0xabcd5555; then empty=1.
REQ-023 dm_busy=1 held, push 4 stores -> st_ready=0, 5th st_valid ignored; release -> 4 DM writes, back-to-back, in order.
REQ-024 Push word op @0x2 -> st_err pulses 1 cycle, count unchanged; push byte 0xfe @0x3 -> enqueued.
REQ-025 FWD_EN: pending words 0x11 then 0x22 @0x4, load word 0x4 -> ld_fwd=1, ld_fwd_data=0x22; load byte 0x5 -> ld_stall=1; without macro both -> ld_stall=1.
REQ-026 Two entries pending, dm_busy=1, assert reset -> next cycle empty=1, DM_write=0, st_ready=1.
